i2c_tx_engine: RTL
==================

I2C_TX_ENGINE -- requirements
Module: i2c_tx_engine

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: width of a TX FIFO word; must be a multiple of 8.
REQ-002 SHALL have parameter DIV, default 4: clock cycles per SCL half-period; minimum 2.
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permits starting a new word.
REQ-006 SHALL have port f_empty  input  1  TX FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  DWIDTH  TX FIFO read data, valid the cycle after rd_en.
REQ-008 SHALL have port rd_en  output  1  TX FIFO pop strobe.
REQ-009 SHALL have port scl_out  output  1  SCL drive; 0 pulls low, 1 releases.
REQ-010 SHALL have port sda_out  output  1  SDA drive; 0 pulls low, 1 releases.
REQ-011 SHALL have port sda_in  input  1  sampled SDA line.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port nack  output  1  sticky NACK error flag.
REQ-014 SHALL have port nack_clr  input  1  clears nack.

Function
REQ-015 SHALL implement states IDLE, POP, LOAD, START, BIT, ACK, STOP.
REQ-016 IDLE -> POP SHALL occur when enable && !f_empty; otherwise remain in IDLE.
REQ-017 rd_en SHALL be high for exactly one cycle (the POP cycle), and never while f_empty is high; one pop per word.
REQ-018 LOAD SHALL capture fifo_data into the shift register, set the byte counter to DWIDTH/8 and the bit counter to 7, then go to START.
REQ-019 START SHALL hold scl_out=1, sda_out=1 for DIV cycles, then scl_out=1, sda_out=0 for DIV cycles, then go to BIT.
REQ-020 Each BIT/ACK slot SHALL be 2*DIV cycles: scl_out=0 for the first DIV cycles, then 1 for the next DIV cycles; sda_out changes only on the first cycle of the low half.
REQ-021 BIT SHALL transmit the current byte MSB first, word bytes most-significant first; after bit 0, go to ACK.
REQ-022 ACK SHALL release SDA (sda_out=1) and sample sda_in on the last cycle of the high half; 0 is ACK, 1 is NACK.
REQ-023 On ACK with bytes remaining, SHALL return to BIT with the next byte; on ACK of the last byte, SHALL go to STOP.
REQ-024 On NACK, SHALL set nack, discard the remaining bytes of the word, and go to STOP.
REQ-025 STOP SHALL drive scl_out=0, sda_out=0 for DIV cycles, then scl_out=1, sda_out=0 for DIV cycles, then scl_out=1, sda_out=1 for DIV cycles, then go to IDLE.
REQ-026 Each word SHALL get its own START/STOP; IDLE lasts at least one cycle between words.
REQ-027 Deasserting enable mid-word SHALL NOT abort the word; it only blocks the next IDLE -> POP.
REQ-028 If nack_clr is high in the same cycle that nack is set, the set SHALL win.
REQ-029 Counters SHALL be sized to hold DIV-1, 7 and DWIDTH/8 exactly; no wrap occurs within a word.
REQ-030 Word duration from POP to IDLE SHALL be 2 + 2*DIV + (DWIDTH/8)*9*2*DIV + 3*DIV cycles without NACK.

Reset
REQ-031 Reset low SHALL immediately force state IDLE, rd_en=0, scl_out=1, sda_out=1, busy=0, nack=0, and clear all counters and the shift register.
REQ-032 Reset mid-word SHALL abandon the word without generating STOP; the popped word is lost.
REQ-033 Release of reset SHALL NOT cause a pop until enable && !f_empty is sampled in IDLE.

Verification (DWIDTH=32, DIV=4)
REQ-034 SHALL cover: fifo_data=32'hA5_3C_0F_81, all ACK -> exactly one rd_en pulse; SDA bytes A5,3C,0F,81 MSB first; START/STOP shapes as REQ-019/025; 310 cycles POP to IDLE.
REQ-035 SHALL cover: sda_in=1 at ACK of byte 2 -> nack=1; bytes 3-4 not sent; STOP follows; nack stays 1 until nack_clr.
REQ-036 SHALL cover: f_empty=1 with enable=1 for 50 cycles -> rd_en never asserted, busy=0, scl_out=sda_out=1.
REQ-037 SHALL cover: two queued words with enable held high -> two rd_en pulses, two START/STOP pairs, at least one IDLE cycle between them.
REQ-038 SHALL cover: reset low during byte 2 bit 4 -> same-cycle scl_out=1, sda_out=1, busy=0; after release, the next word starts from POP.
REQ-039 SHALL cover: enable dropped during byte 1 -> current word completes all 4 bytes, then no further pop.

Source files
------------

// File: rtl/i2c_tx_engine.sv
// I2C transmit engine: pops one DWIDTH-bit word from a TX FIFO and sends it
// as a single START / bytes / STOP transaction, MSB first, checking the ACK
// after every byte. SCL and SDA are open-drain style drives (1 = release).
module i2c_tx_engine #(
    parameter int DWIDTH = 32,
    parameter int DIV    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              f_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              rd_en,
    output logic              scl_out,
    output logic              sda_out,
    input  logic              sda_in,
    output logic              busy,
    output logic              nack,
    input  logic              nack_clr
);

    localparam int BYTES  = DWIDTH / 8;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BYTE_W = $clog2(BYTES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [BYTE_W-1:0] BYTES_INIT = BYTE_W'(BYTES);
    localparam logic [BYTE_W-1:0] BYTE_ONE   = BYTE_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        BIT,
        ACK,
        STOP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         phase;
    logic [2:0]         bit_cnt;
    logic [BYTE_W-1:0]  byte_cnt;
    logic [DWIDTH-1:0]  shift_reg;
    logic               div_last;
    logic               state_done;
    logic               nack_set;

    assign div_last = (div_cnt == DIV_LAST);

    // State register; reset drops straight to IDLE, abandoning any word in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus drive; outputs decode from state so reset takes effect at once
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        scl_out    = 1'b1;
        sda_out    = 1'b1;
        busy       = 1'b1;
        state_done = 1'b0;
        nack_set   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable && !f_empty) begin
                    state_next = POP;
                end
            end
            POP: begin
                rd_en      = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                state_next = START;
            end
            START: begin
                sda_out    = (phase == 2'd0);
                state_done = div_last && (phase == 2'd1);
                if (state_done) begin
                    state_next = BIT;
                end
            end
            BIT: begin
                scl_out    = (phase == 2'd1);
                sda_out    = shift_reg[DWIDTH-1];
                state_done = div_last && (phase == 2'd1);
                if (state_done && (bit_cnt == 3'd0)) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                scl_out    = (phase == 2'd1);
                state_done = div_last && (phase == 2'd1);
                if (state_done) begin
                    if (sda_in) begin
                        nack_set   = 1'b1;
                        state_next = STOP;
                    end else if (byte_cnt == BYTE_ONE) begin
                        state_next = STOP;
                    end else begin
                        state_next = BIT;
                    end
                end
            end
            STOP: begin
                scl_out    = (phase != 2'd0);
                sda_out    = (phase == 2'd2);
                state_done = div_last && (phase == 2'd2);
                if (state_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Half-period timer: div_cnt paces each half, phase selects the half within a state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            phase   <= 2'd0;
        end else if (state inside {START, BIT, ACK, STOP}) begin
            if (div_last) begin
                div_cnt <= '0;
                phase   <= state_done ? 2'd0 : phase + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else begin
            div_cnt <= '0;
            phase   <= 2'd0;
        end
    end

    // Word shifter and bit/byte bookkeeping; shifting at slot end moves SDA on the next low half
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    shift_reg <= fifo_data;
                    byte_cnt  <= BYTES_INIT;
                    bit_cnt   <= 3'd7;
                end
                BIT: begin
                    if (state_done) begin
                        shift_reg <= {shift_reg[DWIDTH-2:0], 1'b0};
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                end
                ACK: begin
                    if (state_done) begin
                        if (sda_in) begin
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt - 1'b1;
                            if (byte_cnt != BYTE_ONE) begin
                                bit_cnt <= 3'd7;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky NACK flag; a new NACK outranks a simultaneous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nack <= 1'b0;
        end else if (nack_set) begin
            nack <= 1'b1;
        end else if (nack_clr) begin
            nack <= 1'b0;
        end
    end

endmodule
